// File: rtl/myc64_prg_loader_if.sv
// ----------------------------------------------------------------------------
// myc64_prg_loader_if
// Groups the PRG loader's byte-stream input, C64 write port and status
// outputs into one bundle.
//   slave  : the loader side (consumes stream, drives write port and status)
//   master : the source/core side (drives stream and i_ext_ready)
// Signals:
//   i_data/i_valid/i_last   byte stream in (beat = i_valid & o_ready)
//   o_ready                 loader accepts a byte this cycle
//   o_ext_we/addr/data      write request to the C64 core
//   i_ext_ready             one-cycle write completion pulse from the core
//   o_busy/o_done/o_err     file status; o_end_addr valid from o_done
// ----------------------------------------------------------------------------
interface myc64_prg_loader_if;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_last;
    logic        o_ready;
    logic        o_ext_we;
    logic [15:0] o_ext_addr;
    logic [7:0]  o_ext_data;
    logic        i_ext_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_end_addr;

    modport slave (
        input  i_data, i_valid, i_last, i_ext_ready,
        output o_ready, o_ext_we, o_ext_addr, o_ext_data,
               o_busy, o_done, o_err, o_end_addr
    );

    modport master (
        output i_data, i_valid, i_last, i_ext_ready,
        input  o_ready, o_ext_we, o_ext_addr, o_ext_data,
               o_busy, o_done, o_err, o_end_addr
    );
endinterface

// File: rtl/myc64_prg_loader.sv
// ----------------------------------------------------------------------------
// myc64_prg_loader
// Loads a C64 PRG file from a byte stream into the C64 core's memory.
// Byte 0/1 of the stream are the little-endian load address, every further
// byte is written to consecutive addresses (16-bit, wrapping silently).
// Each write is held until the core returns a one-cycle i_ext_ready pulse or
// TIMEOUT cycles elapse; a timed-out file is aborted and its remaining bytes
// are discarded up to i_last.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   myc64_prg_loader_if.slave (stream in, write port, status out)
// ----------------------------------------------------------------------------
module myc64_prg_loader #(
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    myc64_prg_loader_if.slave  bus
);

    // Wait counter is at least 10 bits, wider if TIMEOUT needs it.
    localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ADDR_LO,
        ADDR_HI,
        FETCH,
        WRITE,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [15:0]     end_q, end_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;

    logic            rdy;
    logic            beat;

    // Every state except WRITE accepts stream bytes.
    assign rdy  = (state_q != WRITE);
    assign beat = bus.i_valid & rdy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        end_d   = end_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ADDR_LO: begin
                if (beat) begin
                    if (bus.i_last) begin
                        // One-byte file has no complete load address.
                        err_d = 1'b1;
                    end else begin
                        addr_d[7:0] = bus.i_data;
                        state_d     = ADDR_HI;
                    end
                end
            end
            ADDR_HI: begin
                if (beat) begin
                    addr_d[15:8] = bus.i_data;
                    if (bus.i_last) begin
                        // Empty payload: end address is the load address.
                        end_d   = {bus.i_data, addr_q[7:0]};
                        done_d  = 1'b1;
                        state_d = ADDR_LO;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (beat) begin
                    data_d  = bus.i_data;
                    last_d  = bus.i_last;
                    wcnt_d  = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A ready pulse on the final wait cycle still completes.
                if (bus.i_ext_ready) begin
                    addr_d = addr_q + 16'd1;
                    if (last_q) begin
                        end_d   = addr_q + 16'd1;
                        done_d  = 1'b1;
                        last_d  = 1'b0;
                        state_d = ADDR_LO;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (wcnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    last_d  = 1'b0;
                    state_d = last_q ? ADDR_LO : DRAIN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (beat && bus.i_last) begin
                    state_d = ADDR_LO;
                end
            end
            default: state_d = ADDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ADDR_LO;
            addr_q  <= '0;
            data_q  <= '0;
            end_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            end_q   <= end_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Write enable decodes straight from the state register so reset drops
    // it without waiting for a clock edge.
    assign bus.o_ready    = rdy;
    assign bus.o_ext_we   = (state_q == WRITE);
    assign bus.o_ext_addr = addr_q;
    assign bus.o_ext_data = data_q;
    assign bus.o_busy     = (state_q != ADDR_LO);
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_end_addr = end_q;

endmodule

// File: doc/myc64_prg_loader.md
MYC64_PRG_LOADER -- requirements
Module: myc64_prg_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: max clk cycles a write may wait for i_ext_ready before abort.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_data  in  8  stream byte.
- i_valid  in  1  i_data valid.
- i_last  in  1  i_data is final byte of file; qualified by i_valid.
- o_ready  out  1  loader accepts byte this cycle.
- o_ext_we  out  1  write request to C64 core.
- o_ext_addr  out  16  write address.
- o_ext_data  out  8  write data.
- i_ext_ready  in  1  one-cycle completion pulse from C64 core.
- o_busy  out  1  file in progress; high in any state except ADDR_LO.
- o_done  out  1  one-cycle pulse, file loaded.
- o_err  out  1  one-cycle pulse, file aborted.
- o_end_addr  out  16  address following last written byte; valid from o_done.

Function
REQ-003 SHALL accept a stream byte only on a cycle with i_valid & o_ready high (a "beat").
REQ-004 SHALL interpret the stream as C64 PRG: byte 0 load address low, byte 1 load address high, remaining bytes payload written to consecutive addresses.
REQ-005 SHALL implement states ADDR_LO, ADDR_HI, FETCH, WRITE, DRAIN.
REQ-006 ADDR_LO: o_ready=1; beat with i_last=0 -> latch addr[7:0], go ADDR_HI; beat with i_last=1 -> o_err pulse, stay ADDR_LO.
REQ-007 ADDR_HI: o_ready=1; beat -> latch addr[15:8]; i_last=0 -> FETCH; i_last=1 -> o_done pulse, o_end_addr=load address, go ADDR_LO (empty payload).
REQ-008 FETCH: o_ready=1, o_ext_we=0; beat -> latch o_ext_data=i_data, record i_last in a last flag, go WRITE.
REQ-009 WRITE: o_ready=0, o_ext_we=1; o_ext_addr and o_ext_data SHALL be stable for the entire WRITE state.
REQ-010 WRITE with i_ext_ready=1: addr <= addr+1 mod 2^16; last flag clear -> FETCH; last flag set -> o_end_addr <= addr+1, o_done pulse next cycle, go ADDR_LO.
REQ-011 o_ext_we SHALL go low on the cycle after the i_ext_ready pulse; one write per ready pulse, never two.
REQ-012 i_ext_ready outside WRITE SHALL be ignored.
REQ-013 Address wrap FFFF->0000 SHALL be silent; writing continues at 0000.
REQ-014 A 10-bit-or-wider wait counter SHALL clear on entry to WRITE and increment each WRITE cycle; reaching TIMEOUT without i_ext_ready -> o_ext_we=0, o_err pulse, go DRAIN if last flag clear, else ADDR_LO.
REQ-015 i_ext_ready on the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no o_err.
REQ-016 DRAIN: o_ready=1, o_ext_we=0; discard beats; beat with i_last=1 -> ADDR_LO; no further o_err/o_done.
REQ-017 o_done and o_err SHALL never assert in the same cycle, each exactly one cycle wide.
REQ-018 Throughput: with i_valid held high, the gap from the i_ext_ready pulse to o_ext_we reasserting SHALL be 2 clk cycles.
REQ-019 o_ext_addr SHALL equal the current write address in all states; o_ext_data holds last latched byte outside WRITE.

Reset
REQ-020 rst low SHALL immediately force: state ADDR_LO, o_ext_we=0, o_ext_addr=0000, o_ext_data=00, o_end_addr=0000, o_done=0, o_err=0, o_busy=0, wait counter=0, last flag=0.
REQ-021 Reset during WRITE SHALL drop o_ext_we asynchronously; the partial file is discarded and no o_done/o_err is issued.
REQ-022 After rst deasserts, o_ready SHALL be 1 on the first clk edge.

Verification
REQ-023 Stream 01 08 A9 00 8D (last on 8D), ready 4 cycles after each we -> writes 0801=A9, 0802=00, 0803=8D, o_done once, o_end_addr=0804.
REQ-024 Stream FE FF 11 22 33 (last on 33) -> writes FFFE=11, FFFF=22, 0000=33, o_end_addr=0001.
REQ-025 Stream 00 C0 (last on C0) -> zero writes, o_done, o_end_addr=C000; stream 00 (last) -> o_err, zero writes.
REQ-026 TIMEOUT=15, 00 10 AA BB CC (last on CC), i_ext_ready never pulses -> o_ext_we high 15 cycles at 1000 then low, o_err once, BB and CC consumed with no writes, next file loads normally.
REQ-027 Assert rst mid-WRITE -> o_ext_we low without a clk edge, no o_done, outputs at reset values; the next file loads correctly.
REQ-028 Spurious i_ext_ready in FETCH, plus ready coincident with timeout -> no extra write, no o_err, addresses sequential.
